program_counter_stage: RTL
==========================

PROGRAM_COUNTER_STAGE -- requirements
Module: program_counter_stage

Interface
- REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
- REQ-002 Parameter WIDTH, default 32: the address width; only 32 is supported.
- REQ-003 Clk  input  1: the single clock; all state updates on the rising edge.
- REQ-004 Reset  input  1: reset is synchronous and active-high, sampled on the rising edge of Clk.
- REQ-005 NextPC  input  32: candidate next PC, driven by the downstream 32-bit 2:1 PC-source select (A = PCPlus4, B = branch target).
- REQ-006 Stall  input  1: hold the current PC and do not issue a new fetch.
- REQ-007 Redirect  input  1: branch taken; squash any in-flight fetch and load NextPC.
- REQ-008 ImemReq  output  1: instruction-memory request valid.
- REQ-009 ImemAddr  output  32: fetch address; always equals PC.
- REQ-010 ImemAck  input  1: instruction memory accepts and completes the current request.
- REQ-011 PC  output  32: the current program counter.
- REQ-012 PCPlus4  output  32: PC + 4, combinational, fed to select input A.
- REQ-013 FetchValid  output  1: registered one-cycle pulse marking a completed, unsquashed fetch.
- REQ-014 AlignFault  output  1: sticky misalignment flag; present only when the macro in REQ-030 is defined.

Function
- REQ-015 The FSM SHALL have three states: FETCH (ImemReq=1), HOLD (ImemReq=0, fetch done, stalled) and KILL (ImemReq=0, squash bubble).
- REQ-016 In FETCH with ImemAck=1, Stall=0 and Redirect=0, the block SHALL set PC<=NextPC, pulse FetchValid next cycle and stay in FETCH, giving 1 fetch per cycle at zero wait.
- REQ-017 In FETCH with ImemAck=1, Stall=1 and Redirect=0, the block SHALL keep PC, pulse FetchValid and go to HOLD.
- REQ-018 In FETCH with ImemAck=0 and Redirect=0, the block SHALL keep PC and ImemAddr stable with ImemReq held at 1, regardless of Stall.
- REQ-019 In HOLD with Stall=0, the block SHALL set PC<=NextPC and go to FETCH; with Stall=1 it SHALL remain in HOLD.
- REQ-020 In any state, Redirect=1 SHALL set PC<=NextPC and go to KILL, with priority over both Stall and ImemAck.
- REQ-021 If ImemAck and Redirect arrive in the same cycle, the acknowledged fetch SHALL be discarded and no FetchValid pulse produced.
- REQ-022 KILL SHALL last exactly one cycle with ImemReq=0; any ImemAck seen in KILL SHALL be ignored; the next state SHALL be FETCH.
- REQ-023 PCPlus4 SHALL wrap modulo 2^32, so PC=32'hFFFF_FFFC gives PCPlus4=32'h0000_0000.
- REQ-024 ImemAddr SHALL change only while ImemReq=0, or in the cycle after an ImemAck.

Reset
- REQ-025 While Reset=1 at a rising edge: PC<=RESET_PC, state<=KILL, FetchValid<=0, AlignFault<=0.
- REQ-026 The first ImemReq=1 SHALL appear in the second cycle after Reset is deasserted, with ImemAddr=RESET_PC.
- REQ-027 Reset during an outstanding request SHALL abandon that request without producing a FetchValid pulse.
- REQ-028 Reset SHALL override Redirect, Stall and ImemAck.

Configuration
- REQ-029 With PC_ALIGN_CHECK_EN undefined, every load SHALL write {NextPC[31:2],2'b00}, and the AlignFault port SHALL be absent.
- REQ-030 With PC_ALIGN_CHECK_EN defined, a load with NextPC[1:0]!=0 SHALL leave PC unchanged, set AlignFault=1 and enter HOLD; the block SHALL stay in HOLD until Reset.

Structure
- REQ-031 Shared package datapath_pkg SHALL hold the FSM state encoding, INSTR_BYTES=4 and the default RESET_PC.
- REQ-032 One sub-module, pc_adder (32-bit +4 incrementer), SHALL produce PCPlus4.

Verification
- REQ-033 Reset then ImemAck tied to 1 with NextPC=PCPlus4 -> PC sequence 0,4,8,C and FetchValid=1 every cycle from the third post-reset cycle.
- REQ-034 ImemAck low for 3 cycles at PC=8 -> ImemReq=1 and ImemAddr=8 held stable for all 3 cycles; PC=C one cycle after the ack.
- REQ-035 Redirect with NextPC=40 in the same cycle as ImemAck at PC=10 -> no FetchValid pulse, one KILL cycle, then ImemAddr=40.
- REQ-036 Stall=1 at ack with PC=20, held for 4 cycles -> HOLD, ImemReq=0, PC=20; Stall released -> PC=NextPC.
- REQ-037 PC=FFFF_FFFC -> PCPlus4=0, and the next PC=0.
- REQ-038 With PC_ALIGN_CHECK_EN defined, NextPC=0x42 -> AlignFault=1 and PC unchanged until Reset; with it undefined -> PC=0x40.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the fetch front end: address type, PC-stage
// state encoding and instruction-size constants.
package datapath_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } pc_state_e;

    // Clears the byte-offset bits so the address lands on an instruction boundary.
    function automatic addr_t word_align(addr_t a);
        return a & ~addr_t'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/program_counter_stage_if.sv
// Fetch-stage bus between the PC stage (slave) and its surroundings (master).
// AlignFault exists only when PC_ALIGN_CHECK_EN is defined.
interface program_counter_stage_if;
    import datapath_pkg::*;

    addr_t NextPC;
    logic  Stall;
    logic  Redirect;
    logic  ImemReq;
    addr_t ImemAddr;
    logic  ImemAck;
    addr_t PC;
    addr_t PCPlus4;
    logic  FetchValid;
`ifdef PC_ALIGN_CHECK_EN
    logic  AlignFault;
`endif

    modport slave (
        input  NextPC, Stall, Redirect, ImemAck,
        output ImemReq, ImemAddr, PC, PCPlus4, FetchValid
`ifdef PC_ALIGN_CHECK_EN
        , output AlignFault
`endif
    );

    modport master (
        output NextPC, Stall, Redirect, ImemAck,
        input  ImemReq, ImemAddr, PC, PCPlus4, FetchValid
`ifdef PC_ALIGN_CHECK_EN
        , input AlignFault
`endif
    );

endinterface

// File: rtl/pc_adder.sv
// Sequential-address incrementer: PC + INSTR_BYTES, wrapping modulo 2^WIDTH.
module pc_adder
    import datapath_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/program_counter_stage.sv
// Program counter and instruction-fetch request FSM (FETCH / HOLD / KILL).
// Optional PC_ALIGN_CHECK_EN: misaligned loads raise a sticky AlignFault instead of being rounded down.
module program_counter_stage
    import datapath_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC,
    parameter int    WIDTH    = ADDR_WIDTH
) (
    input logic                    Clk,
    input logic                    Reset,
    program_counter_stage_if.slave bus
);

    pc_state_e state;
    addr_t     pc;
    logic      imem_req;
    logic      fetch_valid;
    logic      align_fault;

    logic      load;
    pc_state_e load_state;
    addr_t     load_pc;
    logic      load_bad;

    // Redirect wins over Stall and ImemAck in every state.
    assign load = bus.Redirect
               || (state == ST_FETCH && bus.ImemAck && !bus.Stall)
               || (state == ST_HOLD  && !bus.Stall);
    assign load_state = bus.Redirect ? ST_KILL : ST_FETCH;
    assign load_pc    = word_align(bus.NextPC);

`ifdef PC_ALIGN_CHECK_EN
    assign load_bad = (bus.NextPC != load_pc);
`else
    assign load_bad = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
        if (Reset) begin
            pc          <= RESET_PC;
            state       <= ST_KILL;
            imem_req    <= 1'b0;
            fetch_valid <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            fetch_valid <= (state == ST_FETCH) && bus.ImemAck && !bus.Redirect;
            if (!align_fault) begin
                if (load && load_bad) begin
                    align_fault <= 1'b1;
                    state       <= ST_HOLD;
                    imem_req    <= 1'b0;
                end else if (load) begin
                    pc       <= load_pc;
                    state    <= load_state;
                    imem_req <= !bus.Redirect;
                end else if (state == ST_FETCH && bus.ImemAck) begin
                    state    <= ST_HOLD;
                    imem_req <= 1'b0;
                end else if (state == ST_KILL) begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
            end
        end
    end

    pc_adder #(.WIDTH(WIDTH)) u_pc_adder (
        .pc       (pc),
        .pc_plus4 (bus.PCPlus4)
    );

    assign bus.ImemReq    = imem_req;
    assign bus.ImemAddr   = pc;
    assign bus.PC         = pc;
    assign bus.FetchValid = fetch_valid;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.AlignFault = align_fault;
`endif

endmodule
